// File: rtl/core_sched.sv
// core_sched: starts, pauses and resumes NCORES cores and arbitrates their data-memory write/read ports.
// Latency: wake_ack and grants are same-cycle combinational; start/awake/run_en updates appear 1 cycle after acceptance.
// Backpressure: losing wake and pause/resume requests are dropped, never queued; an ungranted memory request stalls its core.
//
// Ports:
//   clk, rst                         single clock, synchronous active-high reset
//   wake_req/wake_tgt/wake_pc        per-source wake requests (slice i belongs to source i)
//   wake_ack                         per-source acceptance, combinational
//   pr_req/pr_tgt/pr_resume          per-source pause (0) / resume (1) requests
//   wr_req, rd_req                   per-core data-memory port requests
//   halted                           per-core halt status
//   start_valid, start_pc            registered start pulse and held start PC per core
//   awake, run_en                    registered per-core state flags
//   wr_grant, rd_grant               combinational one-hot-or-zero round-robin grants
//   stall                            combinational per-core stall
//   all_done                         registered sticky completion flag
module core_sched #(
   parameter int             NCORES  = 4,
   parameter int             PCW     = 16,
   parameter logic [PCW-1:0] BOOT_PC = '0,
   parameter int             CIDW    = $clog2(NCORES)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NCORES-1:0]      wake_req,
   input  logic [NCORES*CIDW-1:0] wake_tgt,
   input  logic [NCORES*PCW-1:0]  wake_pc,
   output logic [NCORES-1:0]      wake_ack,
   input  logic [NCORES-1:0]      pr_req,
   input  logic [NCORES*CIDW-1:0] pr_tgt,
   input  logic [NCORES-1:0]      pr_resume,
   input  logic [NCORES-1:0]      wr_req,
   input  logic [NCORES-1:0]      rd_req,
   input  logic [NCORES-1:0]      halted,
   output logic [NCORES-1:0]      start_valid,
   output logic [NCORES*PCW-1:0]  start_pc,
   output logic [NCORES-1:0]      awake,
   output logic [NCORES-1:0]      run_en,
   output logic [NCORES-1:0]      wr_grant,
   output logic [NCORES-1:0]      rd_grant,
   output logic [NCORES-1:0]      stall,
   output logic                   all_done
);

   // Boot bookkeeping: the boot pulse for core 0 is issued on the first
   // clock after reset release, i.e. whenever boot_done is still clear.
   logic            boot_done;
   logic            boot_now;
   logic [CIDW-1:0] wptr;
   logic [CIDW-1:0] rptr;

   assign boot_now = ~boot_done;

   // Round-robin pick: first eligible index at or after ptr, wrapping.
   // NCORES is a power of two, so CIDW-bit addition wraps for free.
   function automatic logic [NCORES-1:0] rr_pick(input logic [NCORES-1:0] elig,
                                                 input logic [CIDW-1:0]   ptr);
      logic [NCORES-1:0] g;
      logic [CIDW-1:0]   idx;
      logic              found;
      g     = '0;
      found = 1'b0;
      idx   = '0;
      for (int off = 0; off < NCORES; off++) begin
         idx = ptr + CIDW'(off);
         if (!found && elig[idx]) begin
            g[idx] = 1'b1;
            found  = 1'b1;
         end
      end
      return g;
   endfunction

   // Pointer advances to one past the granted index; holds when nothing was granted.
   function automatic logic [CIDW-1:0] next_ptr(input logic [NCORES-1:0] grant,
                                                input logic [CIDW-1:0]   ptr);
      logic [CIDW-1:0] p;
      p = ptr;
      for (int i = 0; i < NCORES; i++) begin
         if (grant[i]) begin
            p = CIDW'(i + 1);
         end
      end
      return p;
   endfunction

   // ------------------------------------------------------------------
   // Wake arbitration: scanning sources in ascending order, the first
   // source to name a target claims it. The claim is consumed even when
   // the target refuses (already awake, or booting now), so higher
   // sources never get a second chance at that target in the same cycle.
   // ------------------------------------------------------------------
   logic [NCORES-1:0] wake_claim;
   logic [NCORES-1:0] wake_hit;
   logic [NCORES-1:0] wake_ack_c;
   logic [CIDW-1:0]   wake_t;
   logic [PCW-1:0]    wake_win_pc [NCORES];

   always_comb begin
      wake_claim = '0;
      wake_hit   = '0;
      wake_ack_c = '0;
      wake_t     = '0;
      for (int k = 0; k < NCORES; k++) begin
         wake_win_pc[k] = '0;
      end
      for (int i = 0; i < NCORES; i++) begin
         wake_t = wake_tgt[i*CIDW +: CIDW];
         if (wake_req[i] && !wake_claim[wake_t]) begin
            wake_claim[wake_t] = 1'b1;
            if (!awake[wake_t] && !(boot_now && (wake_t == '0))) begin
               wake_hit[wake_t]    = 1'b1;
               wake_ack_c[i]       = 1'b1;
               wake_win_pc[wake_t] = wake_pc[i*PCW +: PCW];
            end
         end
      end
      if (rst) begin
         wake_hit   = '0;
         wake_ack_c = '0;
      end
   end

   assign wake_ack = wake_ack_c;

   // ------------------------------------------------------------------
   // Pause/resume arbitration: lowest requesting source per target wins.
   // ------------------------------------------------------------------
   logic [NCORES-1:0] pr_hit;
   logic [NCORES-1:0] pr_val;
   logic [CIDW-1:0]   pr_t;

   always_comb begin
      pr_hit = '0;
      pr_val = '0;
      pr_t   = '0;
      for (int i = 0; i < NCORES; i++) begin
         pr_t = pr_tgt[i*CIDW +: CIDW];
         if (pr_req[i] && !pr_hit[pr_t]) begin
            pr_hit[pr_t] = 1'b1;
            pr_val[pr_t] = pr_resume[i];
         end
      end
   end

   // ------------------------------------------------------------------
   // Memory port arbitration and stall. Only awake, running cores compete.
   // ------------------------------------------------------------------
   logic [NCORES-1:0] wr_elig;
   logic [NCORES-1:0] rd_elig;

   assign wr_elig = wr_req & awake & run_en;
   assign rd_elig = rd_req & awake & run_en;

   always_comb begin
      wr_grant = '0;
      rd_grant = '0;
      stall    = '0;
      if (!rst) begin
         wr_grant = rr_pick(wr_elig, wptr);
         rd_grant = rr_pick(rd_elig, rptr);
         stall    = awake & (~run_en | (wr_req & ~wr_grant) | (rd_req & ~rd_grant));
      end
   end

   // Every awake core is halted; sleeping cores count as finished.
   logic cores_finished;
   assign cores_finished = &(halted | ~awake);

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         boot_done   <= 1'b0;
         start_valid <= '0;
         start_pc    <= '0;
         awake       <= '0;
         run_en      <= '0;
         wptr        <= '0;
         rptr        <= '0;
         all_done    <= 1'b0;
      end else begin
         boot_done   <= 1'b1;
         start_valid <= wake_hit | {{(NCORES-1){1'b0}}, boot_now};
         // Priority per core: boot, then accepted wake, then pause/resume.
         for (int k = 0; k < NCORES; k++) begin
            if ((k == 0) && boot_now) begin
               start_pc[k*PCW +: PCW] <= BOOT_PC;
               awake[k]               <= 1'b1;
               run_en[k]              <= 1'b1;
            end else if (wake_hit[k]) begin
               start_pc[k*PCW +: PCW] <= wake_win_pc[k];
               awake[k]               <= 1'b1;
               run_en[k]              <= 1'b1;
            end else if (pr_hit[k]) begin
               run_en[k]              <= pr_val[k];
            end
         end
         wptr <= next_ptr(wr_grant, wptr);
         rptr <= next_ptr(rd_grant, rptr);
         if (boot_done && cores_finished) begin
            all_done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_core_sched.sv
module tb_core_sched;

   localparam int          NC   = 4;
   localparam int          PW   = 16;
   localparam int          CW   = 2;
   localparam logic [15:0] BOOT = 16'h0000;

   logic            clk;
   logic            rst;
   logic [NC-1:0]   wake_req;
   logic [NC*CW-1:0] wake_tgt;
   logic [NC*PW-1:0] wake_pc;
   logic [NC-1:0]   wake_ack;
   logic [NC-1:0]   pr_req;
   logic [NC*CW-1:0] pr_tgt;
   logic [NC-1:0]   pr_resume;
   logic [NC-1:0]   wr_req;
   logic [NC-1:0]   rd_req;
   logic [NC-1:0]   halted;
   logic [NC-1:0]   start_valid;
   logic [NC*PW-1:0] start_pc;
   logic [NC-1:0]   awake;
   logic [NC-1:0]   run_en;
   logic [NC-1:0]   wr_grant;
   logic [NC-1:0]   rd_grant;
   logic [NC-1:0]   stall;
   logic            all_done;

   int checks   = 0;
   int failures = 0;

   core_sched #(.NCORES(NC), .PCW(PW), .BOOT_PC(BOOT), .CIDW(CW)) dut (
      .clk(clk), .rst(rst),
      .wake_req(wake_req), .wake_tgt(wake_tgt), .wake_pc(wake_pc), .wake_ack(wake_ack),
      .pr_req(pr_req), .pr_tgt(pr_tgt), .pr_resume(pr_resume),
      .wr_req(wr_req), .rd_req(rd_req), .halted(halted),
      .start_valid(start_valid), .start_pc(start_pc), .awake(awake), .run_en(run_en),
      .wr_grant(wr_grant), .rd_grant(rd_grant), .stall(stall), .all_done(all_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [3:0]  m_awake, m_run, m_sv;
   logic [15:0] m_spc [4];
   int          m_wptr, m_rptr;
   logic        m_done, m_boot;

   logic [3:0]  n_awake, n_run, n_sv;
   logic [15:0] n_spc [4];
   int          n_wptr, n_rptr;
   logic        n_done, n_boot;

   logic [3:0]  e_wake_ack, e_wr_grant, e_rd_grant, e_stall;

   // Expected combinational outputs and next state from current inputs.
   task automatic model_comb();
      logic [3:0] wclaim, pclaim;
      int t, c;
      logic boot, fin;
      e_wake_ack = '0; e_wr_grant = '0; e_rd_grant = '0; e_stall = '0;
      n_awake = m_awake; n_run = m_run; n_sv = '0; n_spc = m_spc;
      n_wptr = m_wptr; n_rptr = m_rptr; n_done = m_done; n_boot = 1'b1;
      if (rst) begin
         n_awake = '0; n_run = '0; n_wptr = 0; n_rptr = 0; n_done = 1'b0; n_boot = 1'b0;
         for (int k = 0; k < 4; k++) n_spc[k] = '0;
         return;
      end
      boot = !m_boot;
      wclaim = '0; pclaim = '0;
      for (int s = 0; s < 4; s++) begin
         if (pr_req[s]) begin
            t = int'(pr_tgt[2*s +: 2]);
            if (!pclaim[t]) begin pclaim[t] = 1'b1; n_run[t] = pr_resume[s]; end
         end
      end
      for (int s = 0; s < 4; s++) begin
         if (wake_req[s]) begin
            t = int'(wake_tgt[2*s +: 2]);
            if (!wclaim[t]) begin
               wclaim[t] = 1'b1;
               if (!m_awake[t] && !(boot && t == 0)) begin
                  e_wake_ack[s] = 1'b1; n_sv[t] = 1'b1; n_spc[t] = wake_pc[16*s +: 16];
                  n_awake[t] = 1'b1; n_run[t] = 1'b1;
               end
            end
         end
      end
      if (boot) begin n_sv[0] = 1'b1; n_spc[0] = BOOT; n_awake[0] = 1'b1; n_run[0] = 1'b1; end
      for (int off = 0; off < 4; off++) begin
         c = (m_wptr + off) % 4;
         if (wr_req[c] && m_awake[c] && m_run[c]) begin e_wr_grant[c] = 1'b1; n_wptr = (c + 1) % 4; break; end
      end
      for (int off = 0; off < 4; off++) begin
         c = (m_rptr + off) % 4;
         if (rd_req[c] && m_awake[c] && m_run[c]) begin e_rd_grant[c] = 1'b1; n_rptr = (c + 1) % 4; break; end
      end
      for (int k = 0; k < 4; k++)
         e_stall[k] = m_awake[k] && (!m_run[k] || (wr_req[k] && !e_wr_grant[k]) || (rd_req[k] && !e_rd_grant[k]));
      fin = 1'b1;
      for (int k = 0; k < 4; k++) if (m_awake[k] && !halted[k]) fin = 1'b0;
      n_done = m_done || (m_boot && fin);
   endtask

   task automatic model_commit();
      m_awake = n_awake; m_run = n_run; m_sv = n_sv; m_spc = n_spc;
      m_wptr = n_wptr; m_rptr = n_rptr; m_done = n_done; m_boot = n_boot;
   endtask

   // One clock: model evaluates the inputs, DUT samples them, both advance.
   task automatic tick();
      model_comb();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic clear_inputs();
      wake_req = '0; wake_tgt = '0; wake_pc = '0; pr_req = '0; pr_tgt = '0;
      pr_resume = '0; wr_req = '0; rd_req = '0; halted = '0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      wake_req = 4'b1111; wake_tgt = 8'hE4; wake_pc = 64'h1111_2222_3333_4444;
      pr_req = 4'b1111; wr_req = 4'b1111; rd_req = 4'b1111; halted = 4'b1111;
      tick(); tick();
      checks++; if (start_valid !== 4'b0000) begin failures++; $display("FAIL reset_start_valid got=%b exp=0000", start_valid); end
      checks++; if (start_pc !== 64'h0) begin failures++; $display("FAIL reset_start_pc got=%h exp=0", start_pc); end
      checks++; if (awake !== 4'b0000) begin failures++; $display("FAIL reset_awake got=%b exp=0000", awake); end
      checks++; if (run_en !== 4'b0000) begin failures++; $display("FAIL reset_run_en got=%b exp=0000", run_en); end
      checks++; if (all_done !== 1'b0) begin failures++; $display("FAIL reset_all_done got=%b exp=0", all_done); end
      checks++; if (wake_ack !== 4'b0000) begin failures++; $display("FAIL reset_wake_ack got=%b exp=0000", wake_ack); end
      checks++; if (wr_grant !== 4'b0000 || rd_grant !== 4'b0000) begin failures++; $display("FAIL reset_grants got=%b/%b exp=0000/0000", wr_grant, rd_grant); end
      checks++; if (stall !== 4'b0000) begin failures++; $display("FAIL reset_stall got=%b exp=0000", stall); end
      clear_inputs();
      tick();
   endtask

   task automatic test_boot();
      rst = 1'b0;
      tick();
      checks++; if (start_valid !== 4'b0001) begin failures++; $display("FAIL boot_start_valid got=%b exp=0001", start_valid); end
      checks++; if (start_pc[15:0] !== BOOT) begin failures++; $display("FAIL boot_start_pc got=%h exp=%h", start_pc[15:0], BOOT); end
      checks++; if (awake !== 4'b0001) begin failures++; $display("FAIL boot_awake got=%b exp=0001", awake); end
      checks++; if (run_en !== 4'b0001) begin failures++; $display("FAIL boot_run_en got=%b exp=0001", run_en); end
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++; if (start_valid !== 4'b0000) begin failures++; $display("FAIL boot_no_repeat cyc=%0d got=%b exp=0000", c, start_valid); end
      end
      checks++; if (all_done !== 1'b0) begin failures++; $display("FAIL boot_all_done got=%b exp=0", all_done); end
   endtask

   task automatic test_wake_conflict();
      wake_req = 4'b0110; wake_tgt = 8'h3C; wake_pc = {16'h0000, 16'h0080, 16'h0040, 16'h0000};
      #1;
      checks++; if (wake_ack !== 4'b0010) begin failures++; $display("FAIL conflict_ack got=%b exp=0010", wake_ack); end
      tick(); clear_inputs();
      checks++; if (start_valid !== 4'b1000) begin failures++; $display("FAIL conflict_start got=%b exp=1000", start_valid); end
      checks++; if (start_pc[63:48] !== 16'h0040) begin failures++; $display("FAIL conflict_pc got=%h exp=0040", start_pc[63:48]); end
      checks++; if (awake !== 4'b1001 || run_en !== 4'b1001) begin failures++; $display("FAIL conflict_state got=%b/%b exp=1001/1001", awake, run_en); end
   endtask

   task automatic test_wake_pause();
      wake_req = 4'b0001; wake_tgt = 8'h02; wake_pc = 64'h0000_0000_0000_0100;
      pr_req = 4'b0010; pr_tgt = 8'h08; pr_resume = 4'b0000;
      #1;
      checks++; if (wake_ack !== 4'b0001) begin failures++; $display("FAIL wp_ack got=%b exp=0001", wake_ack); end
      tick(); clear_inputs();
      checks++; if (awake !== 4'b1101 || run_en !== 4'b1101) begin failures++; $display("FAIL wp_state got=%b/%b exp=1101/1101", awake, run_en); end
      checks++; if (start_valid !== 4'b0100 || start_pc[47:32] !== 16'h0100) begin failures++; $display("FAIL wp_start got=%b/%h exp=0100/0100", start_valid, start_pc[47:32]); end
      // wake aimed at an already-awake core
      wake_req = 4'b0010; wake_tgt = 8'h00; wake_pc = 64'h0000_0000_0200_0000;
      #1;
      checks++; if (wake_ack !== 4'b0000) begin failures++; $display("FAIL awake_reject_ack got=%b exp=0000", wake_ack); end
      tick(); clear_inputs();
      checks++; if (start_valid !== 4'b0000 || start_pc[15:0] !== BOOT) begin failures++; $display("FAIL awake_reject_start got=%b/%h exp=0000/%h", start_valid, start_pc[15:0], BOOT); end
      wake_req = 4'b1000; wake_tgt = 8'h40; wake_pc = 64'h0300_0000_0000_0000;
      #1;
      checks++; if (wake_ack !== 4'b1000) begin failures++; $display("FAIL wake1_ack got=%b exp=1000", wake_ack); end
      tick(); clear_inputs();
      checks++; if (awake !== 4'b1111 || run_en !== 4'b1111 || start_valid !== 4'b0010) begin failures++; $display("FAIL wake1_state got=%b/%b/%b exp=1111/1111/0010", awake, run_en, start_valid); end
   endtask

   task automatic test_rr_write();
      logic [3:0] exp_wr [5];
      logic [3:0] exp_rd [2];
      logic [3:0] exp_st [2];
      exp_wr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      wr_req = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++; if (wr_grant !== exp_wr[c]) begin failures++; $display("FAIL rr_wr_grant cyc=%0d got=%b exp=%b", c, wr_grant, exp_wr[c]); end
         checks++; if (stall !== ~exp_wr[c]) begin failures++; $display("FAIL rr_wr_stall cyc=%0d got=%b exp=%b", c, stall, ~exp_wr[c]); end
         tick();
      end
      // reads arbitrate on their own pointer alongside a write grant
      exp_rd = '{4'b0001, 4'b0010};
      exp_st = '{4'b1110, 4'b1101};
      wr_req = 4'b0100; rd_req = 4'b1111;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++; if (wr_grant !== 4'b0100 || rd_grant !== exp_rd[c]) begin failures++; $display("FAIL rr_rd_grant cyc=%0d got=%b/%b exp=0100/%b", c, wr_grant, rd_grant, exp_rd[c]); end
         checks++; if (stall !== exp_st[c]) begin failures++; $display("FAIL rr_rd_stall cyc=%0d got=%b exp=%b", c, stall, exp_st[c]); end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_pause_resume();
      pr_req = 4'b0001; pr_tgt = 8'h01; pr_resume = 4'b0000;
      tick(); clear_inputs(); #1;
      checks++; if (run_en !== 4'b1101 || stall !== 4'b0010) begin failures++; $display("FAIL pause_state got=%b/%b exp=1101/0010", run_en, stall); end
      pr_req = 4'b0100; pr_tgt = 8'h10; pr_resume = 4'b0100;
      tick(); clear_inputs(); #1;
      checks++; if (run_en !== 4'b1111 || stall !== 4'b0000) begin failures++; $display("FAIL resume_state got=%b/%b exp=1111/0000", run_en, stall); end
      pr_req = 4'b0110; pr_tgt = 8'h3C; pr_resume = 4'b0100;
      tick(); clear_inputs();
      checks++; if (run_en !== 4'b0111) begin failures++; $display("FAIL pr_conflict got=%b exp=0111", run_en); end
      pr_req = 4'b0001; pr_tgt = 8'h03; pr_resume = 4'b0001;
      tick(); clear_inputs();
      checks++; if (run_en !== 4'b1111) begin failures++; $display("FAIL pr_resume3 got=%b exp=1111", run_en); end
   endtask

   task automatic test_all_done();
      rst = 1'b1; tick(); rst = 1'b0; tick();
      wake_req = 4'b0001; wake_tgt = 8'h03; wake_pc = 64'h0000_0000_0000_0555;
      tick(); clear_inputs();
      checks++; if (awake !== 4'b1001 || start_pc[63:48] !== 16'h0555) begin failures++; $display("FAIL ad_setup got=%b/%h exp=1001/0555", awake, start_pc[63:48]); end
      halted = 4'b1000; tick(); tick();
      checks++; if (all_done !== 1'b0) begin failures++; $display("FAIL ad_partial got=%b exp=0", all_done); end
      halted = 4'b1001; tick();
      checks++; if (all_done !== 1'b1) begin failures++; $display("FAIL ad_set got=%b exp=1", all_done); end
      halted = 4'b0000;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++; if (all_done !== 1'b1) begin failures++; $display("FAIL ad_sticky cyc=%0d got=%b exp=1", c, all_done); end
      end
      // reset mid-operation with a wake pending to a sleeping core
      rst = 1'b1; wake_req = 4'b0001; wake_tgt = 8'h01; wake_pc = 64'h0000_0000_0000_0999;
      #1;
      checks++; if (wake_ack !== 4'b0000) begin failures++; $display("FAIL midrst_ack got=%b exp=0000", wake_ack); end
      tick(); clear_inputs();
      checks++; if (start_valid !== 4'b0000 || awake !== 4'b0000 || all_done !== 1'b0) begin failures++; $display("FAIL midrst_state got=%b/%b/%b exp=0000/0000/0", start_valid, awake, all_done); end
      // reboot, with a wake to core 0 in the boot cycle itself
      rst = 1'b0; wake_req = 4'b0100; wake_tgt = 8'h00; wake_pc = 64'h0000_7777_0000_0000;
      #1;
      checks++; if (wake_ack !== 4'b0000) begin failures++; $display("FAIL reboot_ack got=%b exp=0000", wake_ack); end
      tick(); clear_inputs();
      checks++; if (start_valid !== 4'b0001 || start_pc[15:0] !== BOOT) begin failures++; $display("FAIL reboot_start got=%b/%h exp=0001/%h", start_valid, start_pc[15:0], BOOT); end
   endtask

   task automatic test_random();
      logic [63:0] exp_pc;
      for (int c = 0; c < 400; c++) begin
         rst       = ($urandom_range(0, 63) == 0);
         wake_req  = 4'($urandom & $urandom);
         wake_tgt  = 8'($urandom);
         wake_pc   = {32'($urandom), 32'($urandom)};
         pr_req    = 4'($urandom & $urandom & $urandom);
         pr_tgt    = 8'($urandom);
         pr_resume = 4'($urandom);
         wr_req    = 4'($urandom);
         rd_req    = 4'($urandom);
         halted    = 4'($urandom | $urandom);
         #1;
         model_comb();
         checks++; if (wake_ack !== e_wake_ack) begin failures++; $display("FAIL rnd_wake_ack cyc=%0d got=%b exp=%b", c, wake_ack, e_wake_ack); end
         checks++; if (wr_grant !== e_wr_grant) begin failures++; $display("FAIL rnd_wr_grant cyc=%0d got=%b exp=%b", c, wr_grant, e_wr_grant); end
         checks++; if (rd_grant !== e_rd_grant) begin failures++; $display("FAIL rnd_rd_grant cyc=%0d got=%b exp=%b", c, rd_grant, e_rd_grant); end
         checks++; if (stall !== e_stall) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, stall, e_stall); end
         tick();
         exp_pc = {m_spc[3], m_spc[2], m_spc[1], m_spc[0]};
         checks++; if (start_valid !== m_sv) begin failures++; $display("FAIL rnd_start_valid cyc=%0d got=%b exp=%b", c, start_valid, m_sv); end
         checks++; if (start_pc !== exp_pc) begin failures++; $display("FAIL rnd_start_pc cyc=%0d got=%h exp=%h", c, start_pc, exp_pc); end
         checks++; if (awake !== m_awake || run_en !== m_run) begin failures++; $display("FAIL rnd_state cyc=%0d got=%b/%b exp=%b/%b", c, awake, run_en, m_awake, m_run); end
         checks++; if (all_done !== m_done) begin failures++; $display("FAIL rnd_all_done cyc=%0d got=%b exp=%b", c, all_done, m_done); end
      end
      clear_inputs();
      rst = 1'b0;
   endtask

   initial begin
      m_awake = '0; m_run = '0; m_sv = '0; m_wptr = 0; m_rptr = 0; m_done = 1'b0; m_boot = 1'b0;
      for (int k = 0; k < 4; k++) m_spc[k] = '0;
      clear_inputs();
      rst = 1'b1;
      test_reset();
      test_boot();
      test_wake_conflict();
      test_wake_pause();
      test_rr_write();
      test_pause_resume();
      test_all_done();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
